// File: rtl/tia_hsync_sequencer.sv
// TIA horizontal timing: divides the colour clock into HPHI1/HPHI2 phases and
// steps a 57-count line counter that sequences the HSYNC, HBLANK and burst latches.
module tia_hsync_sequencer #(
  parameter int unsigned EndCount  = 56,
  parameter int unsigned ShsCount  = 4,
  parameter int unsigned RhsCount  = 8,
  parameter int unsigned RcbCount  = 12,
  parameter int unsigned RhbCount  = 16,
  parameter int unsigned LrhbCount = 18
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rsync_i,
  input  logic       hmove_i,
  output logic       hphi1_o,
  output logic       hphi2_o,
  output logic [5:0] count_o,
  output logic       hsync_o,
  output logic       hblank_o,
  output logic       color_burst_o,
  output logic       hmove_latch_o,
  output logic       line_start_o
);

  localparam logic [5:0] EndC  = 6'(EndCount);
  localparam logic [5:0] ShsC  = 6'(ShsCount);
  localparam logic [5:0] RhsC  = 6'(RhsCount);
  localparam logic [5:0] RcbC  = 6'(RcbCount);
  localparam logic [5:0] RhbC  = 6'(RhbCount);
  localparam logic [5:0] LrhbC = 6'(LrhbCount);

  logic [1:0] ph_q, ph_d;
  logic [5:0] count_q, count_d;
  logic       hblank_q, hblank_d;
  logic       hsync_q, hsync_d;
  logic       cb_q, cb_d;
  logic       hmove_latch_q, hmove_latch_d;

  logic       advance;
  logic [5:0] count_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ph_q          <= 2'd0;
      count_q       <= 6'd0;
      hblank_q      <= 1'b1;
      hsync_q       <= 1'b0;
      cb_q          <= 1'b0;
      hmove_latch_q <= 1'b0;
    end else begin
      ph_q          <= ph_d;
      count_q       <= count_d;
      hblank_q      <= hblank_d;
      hsync_q       <= hsync_d;
      cb_q          <= cb_d;
      hmove_latch_q <= hmove_latch_d;
    end
  end

  always_comb begin
    ph_d          = ph_q + 2'd1;
    count_d       = count_q;
    hblank_d      = hblank_q;
    hsync_d       = hsync_q;
    cb_d          = cb_q;
    hmove_latch_d = hmove_latch_q;

    advance = (ph_q == 2'd3);
    count_n = (count_q == EndC) ? 6'd0 : count_q + 6'd1;

    if (rsync_i) begin
      ph_d     = 2'd0;
      count_d  = 6'd0;
      hblank_d = 1'b1;
      hsync_d  = 1'b0;
      cb_d     = 1'b0;
    end else if (advance) begin
      // Latch events decode the count being loaded, so they line up with it.
      count_d = count_n;
      if (count_n == 6'd0) begin
        hblank_d      = 1'b1;
        hmove_latch_d = 1'b0;
      end
      if (count_n == ShsC) hsync_d = 1'b1;
      if (count_n == RhsC) begin
        hsync_d = 1'b0;
        cb_d    = 1'b1;
      end
      if (count_n == RcbC) cb_d = 1'b0;
      if (count_n == RhbC && !hmove_latch_q) hblank_d = 1'b0;
      if (count_n == LrhbC && hmove_latch_q) hblank_d = 1'b0;
    end

    // A fresh HMOVE always wins over the start-of-line clear.
    if (hmove_i) hmove_latch_d = 1'b1;
  end

  assign hphi1_o       = (ph_q == 2'd1);
  assign hphi2_o       = (ph_q == 2'd3);
  assign count_o       = count_q;
  assign hsync_o       = hsync_q;
  assign hblank_o      = hblank_q;
  assign color_burst_o = cb_q;
  assign hmove_latch_o = hmove_latch_q;
  assign line_start_o  = (count_q == 6'd0) && (ph_q == 2'd0);

endmodule
